// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 stream emulator.
//   state_t          : frame sequencing states
//   BAR_*            : RGB565 colour-bar constants, left to right
//   BYTES_PER_PIXEL  : RGB565 is carried as two bytes, high byte first
//   bar_color()      : bar index (0..7) to RGB565 colour
package ov7670_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } state_t;

  localparam int BYTES_PER_PIXEL = 2;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ov7670_line_timer.sv
// Horizontal/vertical position counters for the stream emulator.
//   clk, reset_n  : byte clock, async active-low reset
//   clear         : hold both counters at 0 (used while idle)
//   state_lines   : number of lines in the current state (>= 1 when used)
//   hc            : byte position within the line, 0..LINE_CYCLES-1
//   vc            : line index within the current state
//   line_end      : high on the last byte cycle of every line
//   state_end     : high on the last byte cycle of the state's last line
module ov7670_line_timer #(
  parameter int LINE_CYCLES = 1424,
  parameter int HW          = 11,
  parameter int VW          = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic [VW-1:0] state_lines,
  output logic [HW-1:0] hc,
  output logic [VW-1:0] vc,
  output logic          line_end,
  output logic          state_end
);

  localparam logic [HW-1:0] HC_LAST = HW'(LINE_CYCLES - 1);

  assign line_end  = (hc == HC_LAST);
  assign state_end = line_end && (vc == state_lines - VW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (clear) begin
      hc <= '0;
      vc <= '0;
    end else if (line_end) begin
      hc <= '0;
      vc <= state_end ? '0 : vc + VW'(1);
    end else begin
      hc <= hc + HW'(1);
    end
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670 camera emulator: produces VSYNC/HREF/D[7:0] in RGB565, two bytes
// per pixel (high byte first), one byte per clk.
//   clk, reset_n  : byte clock (PCLK domain), async active-low reset
//   enable        : run request, sampled when idle and at each frame end
//   pattern_sel   : 0 = colour bars, 1 = {y,x} ramp; latched at frame start
//   vsync, href   : frame / line valid strobes, active high
//   d             : pixel byte, 0 whenever href is low
//   busy          : high from frame start until return to idle
//   frame_done    : one-cycle pulse on the last cycle of the front porch
// Build option OV7670_STREAM_GEN_FRAME_TAG_EN: a 16-bit frame counter
// replaces pixel 0 of active line 0 so dropped frames can be detected.
// Outputs are registered from the current state/counters, so they trail the
// state register by one cycle; every phase keeps its exact length.
module ov7670_stream_gen
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       pattern_sel,
  output logic       vsync,
  output logic       href,
  output logic [7:0] d,
  output logic       busy,
  output logic       frame_done
);

  localparam int LINE_CYCLES = BYTES_PER_PIXEL * H_ACTIVE + H_BLANK;
  localparam int HW          = $clog2(LINE_CYCLES);
  localparam int VW          = 16;
  localparam logic [HW-1:0] HREF_END = HW'(BYTES_PER_PIXEL * H_ACTIVE);
  localparam logic [15:0]   BAR_W    = 16'(H_ACTIVE / 8);

  state_t          state, state_nx;
  logic [HW-1:0]   hc;
  logic [VW-1:0]   vc;
  logic [VW-1:0]   state_lines;
  logic            line_end, state_end;
  logic            pat_q, load_pat, frame_end;
  logic            vsync_nx, href_nx, busy_nx;
  logic [7:0]      d_nx;
  logic [15:0]     x_pos, pat_pixel, pixel;
  logic [2:0]      bar_idx;

  ov7670_line_timer #(
    .LINE_CYCLES (LINE_CYCLES),
    .HW          (HW),
    .VW          (VW)
  ) u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (state == IDLE),
    .state_lines (state_lines),
    .hc          (hc),
    .vc          (vc),
    .line_end    (line_end),
    .state_end   (state_end)
  );

  always_comb begin
    case (state)
      VSYNC:   state_lines = VW'(VSYNC_LINES);
      VBACK:   state_lines = VW'(V_BACK);
      ACTIVE:  state_lines = VW'(V_ACTIVE);
      VFRONT:  state_lines = VW'(V_FRONT);
      default: state_lines = VW'(1);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Zero-line porches are skipped; with no front porch the frame ends on the
  // last active cycle.
  always_comb begin
    state_nx  = state;
    load_pat  = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nx = VSYNC;
          load_pat = 1'b1;
        end
      end
      VSYNC: begin
        if (line_end && state_end) state_nx = (V_BACK == 0) ? ACTIVE : VBACK;
      end
      VBACK: begin
        if (line_end && state_end) state_nx = ACTIVE;
      end
      ACTIVE: begin
        if (line_end && state_end) begin
          if (V_FRONT == 0) begin
            frame_end = 1'b1;
            load_pat  = enable;
            state_nx  = enable ? VSYNC : IDLE;
          end else begin
            state_nx = VFRONT;
          end
        end
      end
      VFRONT: begin
        if (line_end && state_end) begin
          frame_end = 1'b1;
          load_pat  = enable;
          state_nx  = enable ? VSYNC : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      pat_q <= 1'b0;
    else if (load_pat) pat_q <= pattern_sel;
  end

  assign x_pos     = 16'(hc >> 1);
  assign bar_idx   = 3'(x_pos / BAR_W);
  // Ramp is {y[7:0], x[7:0]}; the shift drops the upper line bits.
  assign pat_pixel = pat_q ? ((vc << 8) | (x_pos & 16'h00FF)) : bar_color(bar_idx);

`ifdef OV7670_STREAM_GEN_FRAME_TAG_EN
  logic [15:0] frame_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       frame_cnt <= '0;
    else if (frame_end) frame_cnt <= frame_cnt + 16'd1;
  end

  assign pixel = (vc == '0 && hc < HW'(BYTES_PER_PIXEL)) ? frame_cnt : pat_pixel;
`else
  assign pixel = pat_pixel;
`endif

  always_comb begin
    vsync_nx = (state == VSYNC);
    busy_nx  = (state != IDLE);
    href_nx  = (state == ACTIVE) && (hc < HREF_END);
    d_nx     = 8'h00;
    if (href_nx) d_nx = hc[0] ? pixel[7:0] : pixel[15:8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync      <= 1'b0;
      href       <= 1'b0;
      d          <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vsync      <= vsync_nx;
      href       <= href_nx;
      d          <= d_nx;
      busy       <= busy_nx;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen with an 8x4 active frame:
// line = 20 byte cycles, frame = 7 lines = 140 cycles.
module tb_ov7670_stream_gen;

  localparam int HA = 8, HB = 4, VA = 4, VS = 1, VBK = 1, VF = 1;
`ifdef OV7670_STREAM_GEN_FRAME_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       pattern_sel = 1'b0;
  logic       vsync, href, busy, frame_done;
  logic [7:0] d;

  always #5 clk = ~clk;

  ov7670_stream_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VSYNC_LINES(VS), .V_BACK(VBK), .V_FRONT(VF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
    .vsync(vsync), .href(href), .d(d), .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    int         cyc;
    logic       vs;
    logic       hr;
    logic       bz;
    logic       fd;
    logic [7:0] dv;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] bars [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                            8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
  int checks = 0;
  int errors = 0;
  int cyc;

  function automatic void add(input int c, input logic vs, input logic hr,
                              input logic bz, input logic fd, input logic [7:0] dv);
    vec_t v;
    v.cyc = c; v.vs = vs; v.hr = hr; v.bz = bz; v.fd = fd; v.dv = dv;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [31:0] outs();
    return 32'({vsync, href, busy, frame_done, d});
  endfunction

  initial begin
    int vi, vs1, vs2, plen, bad_len, bad_bar, d_blank, busy_low, vcnt;
    logic href_prev;
    logic [7:0] exp_b;
    int rises[$];
    int fds[$];

    // cycle index = edges after the one that first samples enable=1
    // frame 1: colour bars; frame 2, 3: ramp; enable drops during frame 3
    add(0,   0, 0, 0, 0, 8'h00);
    add(1,   1, 0, 1, 0, 8'h00);
    add(20,  1, 0, 1, 0, 8'h00);
    add(21,  0, 0, 1, 0, 8'h00);
    add(40,  0, 0, 1, 0, 8'h00);
    add(41,  0, 1, 1, 0, TAG ? 8'h00 : 8'hFF);
    add(42,  0, 1, 1, 0, TAG ? 8'h00 : 8'hFF);
    add(44,  0, 1, 1, 0, 8'hE0);
    add(49,  0, 1, 1, 0, 8'hF8);
    add(54,  0, 1, 1, 0, 8'h1F);
    add(56,  0, 1, 1, 0, 8'h00);
    add(57,  0, 0, 1, 0, 8'h00);
    add(61,  0, 1, 1, 0, 8'hFF);
    add(139, 0, 0, 1, 0, 8'h00);
    add(140, 0, 0, 1, 1, 8'h00);
    add(141, 1, 0, 1, 0, 8'h00);
    add(182, 0, 1, 1, 0, TAG ? 8'h01 : 8'h00);
    add(221, 0, 1, 1, 0, 8'h02);
    add(222, 0, 1, 1, 0, 8'h00);
    add(224, 0, 1, 1, 0, 8'h01);
    add(235, 0, 1, 1, 0, 8'h02);
    add(236, 0, 1, 1, 0, 8'h07);
    add(237, 0, 0, 1, 0, 8'h00);
    add(322, 0, 1, 1, 0, TAG ? 8'h02 : 8'h00);
    add(396, 0, 1, 1, 0, 8'h07);
    add(420, 0, 0, 1, 1, 8'h00);
    add(421, 0, 0, 0, 0, 8'h00);
    add(450, 0, 0, 0, 0, 8'h00);

    cyc = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 32'h0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_outputs", outs(), 32'h0);

    pattern_sel = 1'b0;
    enable = 1'b1;
    cyc = -1;
    vi = 0; vs1 = 0; vs2 = 0; plen = 0; bad_len = 0; bad_bar = 0;
    d_blank = 0; busy_low = 0; href_prev = 1'b0;
    while (cyc < 470) begin
      next();
      if (vi < vecs.size() && vecs[vi].cyc == cyc) begin
        chk($sformatf("vec_c%0d", cyc), outs(),
            32'({vecs[vi].vs, vecs[vi].hr, vecs[vi].bz, vecs[vi].fd, vecs[vi].dv}));
        vi++;
      end
      if (cyc <= 139 && vsync) vs1++;
      if (cyc >= 140 && cyc <= 279 && vsync) vs2++;
      if (href && !href_prev) begin
        if (cyc < 280) rises.push_back(cyc);
        plen = 0;
      end
      if (!href && href_prev && cyc <= 280 && plen != 16) bad_len++;
      if (href) begin
        if (cyc < 140) begin
          exp_b = (TAG && rises.size() == 1 && plen < 2) ? 8'h00 : bars[plen % 16];
          if (d !== exp_b) bad_bar++;
        end
        plen++;
      end
      if (!href && d !== 8'h00) d_blank++;
      if (frame_done && cyc <= 280) fds.push_back(cyc);
      if (cyc >= 1 && cyc <= 280 && !busy) busy_low++;
      href_prev = href;
      if (cyc == 59)  pattern_sel = 1'b1;
      if (cyc == 329) enable = 1'b0;
    end

    chk("vectors_reached", vi, vecs.size());
    chk("vsync_len_f1", vs1, 20);
    chk("vsync_len_f2", vs2, 20);
    chk("href_pulses", rises.size(), 8);
    foreach (rises[i]) chk($sformatf("href_rise_%0d", i), rises[i], 41 + 140 * (i / 4) + 20 * (i % 4));
    chk("href_len_bad", bad_len, 0);
    chk("bar_bytes_bad", bad_bar, 0);
    chk("d_in_blank", d_blank, 0);
    chk("frame_done_cnt", fds.size(), 2);
    if (fds.size() == 2) begin
      chk("frame_done_0", fds[0], 140);
      chk("frame_done_1", fds[1], 280);
    end
    chk("busy_gap", busy_low, 0);

    // re-enable from idle: vsync one cycle after the sampling edge
    chk("idle_before_reen", outs(), 32'h0);
    enable = 1'b1;
    cyc = -1;
    next();
    chk("reen_c0", outs(), 32'h0);
    next();
    chk("reen_c1", 32'({vsync, busy}), 32'h3);
    while (cyc < 50) next();
    chk("pre_reset_href", 32'(href), 32'h1);

    // async reset mid-ACTIVE, checked before the next clock edge
    #2 reset_n = 1'b0;
    #1 chk("reset_async", outs(), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc = -1;
    next();
    chk("post_rst_c0", outs(), 32'h0);
    vcnt = 0;
    while (cyc < 22) begin
      next();
      if (vsync) vcnt++;
      if (cyc == 1) chk("post_rst_c1", 32'({vsync, busy}), 32'h3);
    end
    chk("post_rst_vsync_len", vcnt, 20);
    while (cyc < 43) next();
    chk("post_rst_byte2", 32'({href, d}), 32'h100);
    next();
    chk("post_rst_byte3", 32'({href, d}), 32'h101);
    while (cyc < 140) next();
    chk("post_rst_fd", 32'({frame_done, busy}), 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
